// File: rtl/alu_instr_encoder_if.sv
// Handshake bundle between the program loader, the ALU instruction encoder
// and the instruction-memory writer.
interface alu_instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic              in_imm;
  logic              in_setcc;
  logic [2:0]        in_rd;
  logic [2:0]        in_ra;
  logic [2:0]        in_rb;
  logic [3:0]        in_immb;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  // Loader / memory-writer side.
  modport master (
    output in_valid, in_op, in_imm, in_setcc, in_rd, in_ra, in_rb, in_immb,
    input  in_ready,
    input  out_valid, out_instr, out_addr,
    output out_ready
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_op, in_imm, in_setcc, in_rd, in_ra, in_rb, in_immb,
    output in_ready,
    output out_valid, out_instr, out_addr,
    input  out_ready
  );
endinterface

// File: rtl/alu_instr_encoder.sv
// Packs ALU operation fields into 16-bit instruction words and streams them
// out with sequential instruction-memory write addresses.
module alu_instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                restart,
  alu_instr_encoder_if.slave  bus,
  output logic                full,
  output logic                err_illegal,
  output logic [7:0]          err_count
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_MOV  = 4'h1, OP_SUB  = 4'h2, OP_SHL  = 4'h3,
    OP_SHAR = 4'h4, OP_SHLR = 4'h5, OP_RL   = 4'h6, OP_RR   = 4'h7,
    OP_AND  = 4'h8, OP_OR   = 4'h9, OP_NOT  = 4'hB, OP_MULT = 4'hC
  } op_e;

  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DEPTH - 1);

  logic              out_valid_q;
  logic [15:0]       out_instr_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              illegal;
  logic [15:0]       word;
  logic              accept;
  logic              drain;
  op_e               op;

  assign op = op_e'(bus.in_op);

  assign bus.in_ready  = !full && !restart && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign drain         = out_valid_q && bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  // The held word always sits at the write pointer; it only advances on drain.
  assign bus.out_addr  = ptr_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    illegal = 1'b0;
    case (op)
      OP_ADD, OP_MOV, OP_SUB, OP_SHL, OP_SHAR, OP_SHLR,
      OP_RL, OP_RR, OP_AND, OP_OR, OP_MULT: illegal = 1'b0;
      OP_NOT:                               illegal = bus.in_imm;
      default:                              illegal = 1'b1;
    endcase
  end

  // Fields an opcode does not use are zeroed so stale loader data never leaks.
  always_comb begin
    word        = '0;
    word[15:12] = bus.in_op;
    word[11]    = bus.in_imm;
    word[10]    = bus.in_setcc;
    word[9:7]   = bus.in_rd;
    if (bus.in_imm) begin
      word[6:4] = (op == OP_MOV) ? 3'b000 : bus.in_ra;
      word[3:0] = bus.in_immb;
    end else begin
      word[6:4] = bus.in_ra;
      word[3:1] = (op == OP_MOV || op == OP_NOT) ? 3'b000 : bus.in_rb;
      word[0]   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      ptr_q       <= '0;
      count_q     <= '0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else begin
      err_illegal <= 1'b0;
      if (restart) begin
        out_valid_q <= 1'b0;
        ptr_q       <= '0;
        count_q     <= '0;
        full        <= 1'b0;
      end else begin
        if (drain) begin
          out_valid_q <= 1'b0;
          count_q     <= count_q + 1'b1;
          if (count_q == LAST_CNT) full <= 1'b1;
          if (ptr_q != LAST_ADDR) ptr_q <= ptr_q + 1'b1;
        end
        if (accept) begin
          if (illegal) begin
            err_illegal <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 1'b1;
          end else begin
            out_valid_q <= 1'b1;
            out_instr_q <= word;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Directed-vector bench for alu_instr_encoder built with DEPTH=4 so the
// full/restart boundary is reachable in a few words.
module tb_alu_instr_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       restart;
  logic       full;
  logic       err_illegal;
  logic [7:0] err_count;
  int         n_vec = 0;
  int         n_err = 0;

  alu_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  alu_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .bus         (bus),
    .full        (full),
    .err_illegal (err_illegal),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic imm, input logic setcc,
                       input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [3:0] immb);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_imm   = imm;
    bus.in_setcc = setcc;
    bus.in_rd    = rd;
    bus.in_ra    = ra;
    bus.in_rb    = rb;
    bus.in_immb  = immb;
  endtask

  initial begin
    reset         = 1'b1;
    restart       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 4'h0);
    bus.in_valid  = 1'b0;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", 32'(bus.out_instr), 32'h0);
    check("rst_out_addr",  32'(bus.out_addr),  32'd0);
    check("rst_full",      32'(full),          32'd0);
    check("rst_err_ill",   32'(err_illegal),   32'd0);
    check("rst_err_cnt",   32'(err_count),     32'd0);
    reset = 1'b0;
    step();

    // ADD setcc rd3 ra5 rb6 (immb ignored)
    drive(4'h0, 1'b0, 1'b1, 3'd3, 3'd5, 3'd6, 4'hF);
    #1 check("add_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    check("add_valid", 32'(bus.out_valid), 32'd1);
    check("add_instr", 32'(bus.out_instr), 32'h05DC);
    check("add_addr",  32'(bus.out_addr),  32'd0);

    // MOVI accepted while ADD drains: no bubble, next address
    bus.out_ready = 1'b1;
    drive(4'h1, 1'b1, 1'b0, 3'd2, 3'd7, 3'd0, 4'hA);
    step();
    check("movi_valid", 32'(bus.out_valid), 32'd1);
    check("movi_instr", 32'(bus.out_instr), 32'h190A);
    check("movi_addr",  32'(bus.out_addr),  32'd1);
    bus.in_valid = 1'b0;
    step();
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    // Illegal: NOT immediate, then op 1110
    drive(4'hB, 1'b1, 1'b0, 3'd1, 3'd1, 3'd1, 4'h1);
    step();
    check("noti_valid",   32'(bus.out_valid), 32'd0);
    check("noti_err_ill", 32'(err_illegal),   32'd1);
    check("noti_err_cnt", 32'(err_count),     32'd1);
    drive(4'hE, 1'b0, 1'b0, 3'd1, 3'd1, 3'd1, 4'h1);
    step();
    check("opE_valid",   32'(bus.out_valid), 32'd0);
    check("opE_err_ill", 32'(err_illegal),   32'd1);
    check("opE_err_cnt", 32'(err_count),     32'd2);
    bus.in_valid = 1'b0;
    step();
    check("err_pulse_end", 32'(err_illegal), 32'd0);

    // SUB rd1 ra2 rb3 lands at the unmoved pointer
    drive(4'h2, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 4'h7);
    step();
    check("sub_instr", 32'(bus.out_instr), 32'h20A6);
    check("sub_addr",  32'(bus.out_addr),  32'd2);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Restart drops the held word, keeps the error count
    restart = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 4'h0);
    #1 check("restart_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    step();
    restart = 1'b0;
    check("rs1_valid",   32'(bus.out_valid), 32'd0);
    check("rs1_addr",    32'(bus.out_addr),  32'd0);
    check("rs1_err_cnt", 32'(err_count),     32'd2);

    // Backpressure: AND held for 5 cycles while OR-imm waits
    drive(4'h8, 1'b0, 1'b0, 3'd4, 3'd1, 3'd2, 4'h0);
    step();
    check("and_addr", 32'(bus.out_addr), 32'd0);
    drive(4'h9, 1'b1, 1'b1, 3'd7, 3'd3, 3'd0, 4'h5);
    for (int i = 0; i < 5; i++) begin
      check("hold_in_ready", 32'(bus.in_ready),  32'd0);
      check("hold_instr",    32'(bus.out_instr), 32'h8214);
      check("hold_addr",     32'(bus.out_addr),  32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    check("ori_instr", 32'(bus.out_instr), 32'h9FB5);
    check("ori_addr",  32'(bus.out_addr),  32'd1);
    drive(4'h3, 1'b0, 1'b0, 3'd0, 3'd0, 3'd7, 4'h0);
    step();
    check("shl_instr", 32'(bus.out_instr), 32'h300E);
    check("shl_addr",  32'(bus.out_addr),  32'd2);
    drive(4'hC, 1'b1, 1'b0, 3'd5, 3'd6, 3'd0, 4'h3);
    step();
    check("multi_instr", 32'(bus.out_instr), 32'hCAE3);
    check("multi_addr",  32'(bus.out_addr),  32'd3);
    check("multi_full",  32'(full),          32'd0);
    bus.in_valid = 1'b0;
    step();

    // Region exhausted
    check("full_set",   32'(full),          32'd1);
    check("full_valid", 32'(bus.out_valid), 32'd0);
    check("full_addr",  32'(bus.out_addr),  32'd3);
    drive(4'h0, 1'b0, 1'b0, 3'd1, 3'd1, 3'd1, 4'h0);
    #1 check("full_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    check("full_no_accept", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;

    restart = 1'b1;
    step();
    restart = 1'b0;
    check("rs2_full",    32'(full),      32'd0);
    check("rs2_err_cnt", 32'(err_count), 32'd2);

    // MOV reg: rb forced to 0
    bus.out_ready = 1'b0;
    drive(4'h1, 1'b0, 1'b0, 3'd6, 3'd5, 3'd7, 4'h9);
    step();
    bus.in_valid = 1'b0;
    check("mov_valid", 32'(bus.out_valid), 32'd1);
    check("mov_instr", 32'(bus.out_instr), 32'h1350);
    check("mov_addr",  32'(bus.out_addr),  32'd0);

    // Async reset between edges while a word is held
    #3 reset = 1'b1;
    #1;
    check("arst_valid",   32'(bus.out_valid), 32'd0);
    check("arst_instr",   32'(bus.out_instr), 32'h0);
    check("arst_addr",    32'(bus.out_addr),  32'd0);
    check("arst_err_cnt", 32'(err_count),     32'd0);
    check("arst_full",    32'(full),          32'd0);
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_instr_encoder.md
Name: alu_instr_encoder

Overview:
- Reverse direction of the ALU-op instruction decoder.
- Accepts ALU operation fields over a valid/ready handshake and packs them into the 16-bit ALU instruction word.
- Emits each word with a sequential instruction-memory write address over a second valid/ready handshake.
- Used by the program loader/self-test sequencer to build ALU programs in instruction memory; rejects illegal encodings.

Parameters:
ADDR_W, 8, width of instruction-memory write address
DEPTH, 256, number of words the program region holds (1..2**ADDR_W)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
restart  input  1  synchronous; clears address/count/full; drops any held output word
in_valid  input  1  operation fields valid
in_ready  output  1  encoder accepts fields this cycle
in_op  input  4  operation code (instr[15:12])
in_imm  input  1  immediate form (instr[11])
in_setcc  input  1  update condition codes (instr[10])
in_rd  input  3  destination register
in_ra  input  3  source A register
in_rb  input  3  source B register
in_immb  input  4  4-bit immediate
out_valid  output  1  encoded word held
out_ready  input  1  memory writer accepts word
out_instr  output  16  encoded instruction
out_addr  output  ADDR_W  write address of out_instr
full  output  1  DEPTH words emitted
err_illegal  output  1  one-cycle pulse: illegal op accepted and dropped
err_count  output  8  saturating count of illegal ops

Behaviour:
- Reset (async): out_valid=0, out_instr=0, out_addr=0, full=0, err_illegal=0, err_count=0, internal word count=0.
- Opcode map: 0000 ADD, 0001 MOV, 0010 SUB, 0011 SHL, 0100 SHAR, 0101 SHLR, 0110 RL, 0111 RR, 1000 AND, 1001 OR, 1011 NOT, 1100 MULT.
- Illegal: op in {1010,1101,1110,1111}; NOT with in_imm=1.
- Word format: [15:12]=in_op, [11]=in_imm, [10]=in_setcc, [9:7]=in_rd.
  - Register form: [6:4]=in_ra, [3:1]=in_rb, [0]=0.
  - Immediate form: [6:4]=in_ra, [3:0]=in_immb.
- Unused fields are forced to 0, never passed through:
  - MOVI: [6:4]=000.
  - MOV (reg) and NOT: [3:1]=000.
- in_ready = !full && !restart && (!out_valid || out_ready). Combinational pass-through of out_ready.
- Accept occurs when in_valid && in_ready at a rising edge.
  - Legal accept: out_instr/out_valid update on that edge (latency 1). out_addr is the current write pointer.
  - Illegal accept: out_valid deasserts if its word drained the same edge. err_illegal=1 for the next cycle only. err_count += 1, saturating at 255. The pointer does not move.
- Output handshake (out_valid && out_ready): pointer += 1 and word count += 1.
  - When word count reaches DEPTH: full=1 and in_ready=0.
  - out_addr never wraps past DEPTH-1.
- Simultaneous drain and legal accept in the same cycle: the new word is loaded, out_valid stays 1, out_addr = old pointer + 1. No bubble.
- out_instr/out_addr are stable while out_valid && !out_ready.
- restart has priority over all handshakes:
  - Clears pointer, word count, full and out_valid.
  - err_count is kept.
- Reset asserted mid-transfer: the held word is lost; no out handshake occurs.

Test Plan:
- ADD, setcc=1, rd=3, ra=5, rb=6, immb=F -> out_instr=0x05DC at out_addr=0, out_valid on the next cycle.
- MOVI, imm=1, rd=2, ra=7, immb=A -> out_instr=0x190A (ra forced to 0); next word at out_addr=1.
- NOT with imm=1, then op=1110 -> no out_valid; err_illegal pulses twice; err_count=2; next legal word still at the same address.
- Hold out_ready=0 for 5 cycles with in_valid=1:
  - in_ready=0 and out_instr stable.
  - Release: back-to-back words at consecutive addresses, one per cycle.
- DEPTH=4, stream 6 ops with out_ready=1:
  - Addresses 0..3 emitted, then full=1 and in_ready=0.
  - restart -> full=0; next word at addr 0; err_count unchanged.
- Assert reset while out_valid=1 -> all outputs return to reset values immediately, without waiting for a clock edge.
